// File: rtl/legv8_pkg.sv
// Shared LEGv8 datapath definitions: ALU op codes and register addressing.
package legv8_pkg;

  localparam int NREG = 32;
  localparam int XZR  = 31;

  typedef logic [4:0] reg_addr_t;

  typedef enum logic [3:0] {
    ALU_AND   = 4'b0000,
    ALU_OR    = 4'b0001,
    ALU_ADD   = 4'b0010,
    ALU_SUB   = 4'b0110,
    ALU_PASSB = 4'b0111
  } alu_op_t;

endpackage

// File: rtl/operand_stage_regfile.sv
// 32-entry register file: X0..X30 stored, X31 hardwired to zero,
// two combinational read ports with same-cycle writeback bypass.
module regfile
  import legv8_pkg::*;
#(
  parameter int N    = 64,
  parameter int NREG = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  reg_addr_t    ra1,
  input  reg_addr_t    ra2,
  output logic [N-1:0] rd1,
  output logic [N-1:0] rd2,
  input  logic         wb_en,
  input  reg_addr_t    wb_addr,
  input  logic [N-1:0] wb_data
);

  // XZR is never stored, so only NREG-1 physical entries exist
  logic [N-1:0] x_q [NREG-1];

  logic wr_hit;
  assign wr_hit = wb_en && (wb_addr != reg_addr_t'(XZR));

  // array write; reset seeds X_i = i so each register is self-identifying
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG-1; i++) x_q[i] <= N'(i);
    end else if (wr_hit) begin
      x_q[wb_addr] <= wb_data;
    end
  end

  // read port 1: XZR first, then bypass, then array
  always_comb begin
    rd1 = '0;
    if (ra1 == reg_addr_t'(XZR))        rd1 = '0;
    else if (wr_hit && wb_addr == ra1)  rd1 = wb_data;
    else                                rd1 = x_q[ra1];
  end

  // read port 2: same rules as port 1
  always_comb begin
    rd2 = '0;
    if (ra2 == reg_addr_t'(XZR))        rd2 = '0;
    else if (wr_hit && wb_addr == ra2)  rd2 = wb_data;
    else                                rd2 = x_q[ra2];
  end

endmodule

// File: rtl/operand_stage.sv
// Decode/operand-fetch stage: register read, B-operand select and the
// ID/EX pipeline register feeding the ALU. Priority: reset > flush > stall > load.
module operand_stage
  import legv8_pkg::*;
#(
  parameter int N    = 64,
  parameter int NREG = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic         stall,
  input  logic         flush,
  input  reg_addr_t    ra1,
  input  reg_addr_t    ra2,
  input  logic [N-1:0] imm,
  input  logic         alusrc,
  input  logic [3:0]   alucontrol,
  input  reg_addr_t    wa,
  input  logic         regwrite,
  input  logic         wb_en,
  input  reg_addr_t    wb_addr,
  input  logic [N-1:0] wb_data,
  output logic         ex_valid,
  output logic [N-1:0] ex_a,
  output logic [N-1:0] ex_b,
  output logic [3:0]   ex_alucontrol,
  output reg_addr_t    ex_wa,
  output logic         ex_regwrite
);

  logic [N-1:0] rd1, rd2, b_d;
  logic         vld_q, rw_q;
  logic [N-1:0] a_q, b_q;
  logic [3:0]   aluc_q;
  reg_addr_t    wa_q;

  regfile #(.N(N), .NREG(NREG)) u_rf (
    .clk     (clk),
    .reset   (reset),
    .ra1     (ra1),
    .ra2     (ra2),
    .rd1     (rd1),
    .rd2     (rd2),
    .wb_en   (wb_en),
    .wb_addr (wb_addr),
    .wb_data (wb_data)
  );

  assign b_d = alusrc ? imm : rd2;

  // ID/EX register; a stall holds operands as captured, without re-reading
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q  <= 1'b0;
      rw_q   <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      aluc_q <= '0;
      wa_q   <= '0;
    end else if (flush) begin
      vld_q  <= 1'b0;
      rw_q   <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      aluc_q <= '0;
      wa_q   <= '0;
    end else if (!stall) begin
      vld_q  <= in_valid;
      rw_q   <= regwrite & in_valid;
      a_q    <= rd1;
      b_q    <= b_d;
      aluc_q <= alucontrol;
      wa_q   <= wa;
    end
  end

  assign ex_valid      = vld_q;
  assign ex_regwrite   = rw_q;
  assign ex_a          = a_q;
  assign ex_b          = b_q;
  assign ex_alucontrol = aluc_q;
  assign ex_wa         = wa_q;

endmodule
